// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, optional two-entry skid buffer and stall counter
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              acc, pop;
    assign out_valid = state_q != EMPTY;
    assign in_ready  = (SKID != 0) ? in_ready_q : (rst_n && (out_ready || !out_valid));
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;
    // Without a skid entry, accepting while ONE implies a pop, so FULL is unreachable.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        case (state_q)
            EMPTY: if (acc) begin
                state_d     = ONE;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
            ONE: if (acc && pop) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (acc) begin
                state_d     = FULL;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end else if (pop) begin
                state_d = EMPTY;
            end
            FULL: if (pop) begin
                state_d     = ONE;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_ctrl_d = '0;
                skid_data_d = '0;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
        in_ready_d  = state_d != FULL;
        stall_cnt_d = (out_valid && !out_ready && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives SKID=0, SKID=1 and a 4-bit-counter instance against a queue model
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int CW = 16;
    localparam int DW = 160;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          ir[3];
    logic          ov[3];
    logic [CW-1:0] oc[3];
    logic [DW-1:0] od[3];
    logic [15:0]   sc0, sc1;
    logic [3:0]    sc2;
    int            n_chk = 0;
    int            n_pass = 0;
    bit            chk_en = 1'b0;
    ent_t          m_buf[3][2];
    int            m_n[3];
    int            m_stall[3];
    bit            m_rdy[3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc0));
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc1));
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc2));

    task automatic chk(string nm, int k, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s u%0d got %h expected %h at %0t", nm, k, got, exp, $time);
    endtask

    function automatic bit exp_rdy(int k);
        return (k == 1) ? m_rdy[k] : (rst_n && (m_n[k] == 0 || out_ready));
    endfunction

    function automatic logic [DW-1:0] got_sc(int k);
        return (k == 0) ? DW'(sc0) : (k == 1) ? DW'(sc1) : DW'(sc2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k] = 0;
            m_stall[k] = 0;
            m_rdy[k] = 1'b0;
        end
    endtask

    // Model: each instance is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    task automatic model_update();
        bit pop, acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            pop = m_n[k] > 0 && out_ready;
            acc = in_valid && exp_rdy(k);
            if (m_n[k] > 0 && !out_ready && m_stall[k] < ((k == 2) ? 15 : 65535)) m_stall[k]++;
            if (flush) m_n[k] = 0;
            else begin
                if (pop) begin
                    m_buf[k][0] = m_buf[k][1];
                    m_n[k]--;
                end
                if (acc && m_n[k] < 2) begin
                    m_buf[k][m_n[k]] = {in_ctrl, in_data};
                    m_n[k]++;
                end
            end
            m_rdy[k] = m_n[k] < 2;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("out_valid", k, DW'(ov[k]), DW'(m_n[k] > 0));
                chk("out_ctrl", k, DW'(oc[k]), DW'((m_n[k] > 0) ? m_buf[k][0].c : CW'(0)));
                if (m_n[k] > 0) chk("out_data", k, od[k], m_buf[k][0].d);
                chk("in_ready", k, DW'(ir[k]), DW'(exp_rdy(k)));
                chk("stall_cnt", k, got_sc(k), DW'(m_stall[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(bit v, logic [CW-1:0] c, logic [DW-1:0] d, bit rdy, bit fl);
        in_valid = v;
        in_ctrl = c;
        in_data = d;
        out_ready = rdy;
        flush = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, '0, 1, 0);
        model_reset();
        cyc();
        cyc();
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, DW'(ov[k]), '0);
            chk("rst_ready", k, DW'(ir[k]), '0);
            chk("rst_ctrl", k, DW'(oc[k]), '0);
            chk("rst_data", k, od[k], '0);
            chk("rst_stall", k, got_sc(k), '0);
        end
        rst_n = 1'b1;
        cyc();
        // streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1, CW'(i), DW'(32'h1000 + i), 1, 0);
            cyc();
            for (int k = 0; k < 2; k++) begin
                chk("stream_ctrl", k, DW'(oc[k]), DW'(i));
                chk("stream_data", k, od[k], DW'(32'h1000 + i));
            end
        end
        drive(0, '0, '0, 1, 0);
        cyc();
        chk("stream_drain", 1, DW'(ov[1]), '0);
        // backpressure fills the skid entry
        drive(1, 16'h21, DW'(16'h2100), 1, 0);
        cyc();
        drive(1, 16'h22, DW'(16'h2200), 0, 0);
        cyc();
        drive(1, 16'h23, DW'(16'h2300), 0, 0);
        cyc();
        cyc();
        chk("bp_stall", 1, DW'(sc1), DW'(3));
        chk("bp_stall", 0, DW'(sc0), DW'(3));
        chk("bp_ready", 1, DW'(ir[1]), '0);
        chk("bp_head", 1, DW'(oc[1]), DW'(16'h21));
        drive(0, '0, '0, 1, 0);
        cyc();
        chk("bp_second", 1, DW'(oc[1]), DW'(16'h22));
        chk("bp_second_data", 1, od[1], DW'(16'h2200));
        cyc();
        chk("bp_drain", 1, DW'(ov[1]), '0);
        // flush while FULL, then flush with an accepted input
        drive(1, 16'h31, DW'(16'h3100), 1, 0);
        cyc();
        drive(1, 16'h32, DW'(16'h3200), 0, 0);
        cyc();
        chk("fl_full_ready", 1, DW'(ir[1]), '0);
        drive(1, 16'h33, DW'(16'h3300), 0, 1);
        cyc();
        chk("fl_valid", 1, DW'(ov[1]), '0);
        chk("fl_ctrl", 1, DW'(oc[1]), '0);
        chk("fl_ready", 1, DW'(ir[1]), DW'(1));
        chk("fl_valid", 0, DW'(ov[0]), '0);
        drive(1, 16'h34, DW'(16'h3400), 1, 1);
        cyc();
        chk("fl_discard", 0, DW'(ov[0]), '0);
        chk("fl_discard", 1, DW'(ov[1]), '0);
        drive(0, '0, '0, 1, 0);
        cyc();
        chk("fl_never", 1, DW'(ov[1]), '0);
        // walking ones over every bit
        for (int b = 0; b < DW; b++) begin
            drive(1, CW'(1) << (b % CW), DW'(1) << b, 1, 0);
            cyc();
            chk("walk_data", 0, od[0], DW'(1) << b);
            chk("walk_ctrl", 1, DW'(oc[1]), DW'(CW'(1) << (b % CW)));
        end
        drive(0, '0, '0, 1, 0);
        cyc();
        // asynchronous reset mid-cycle while FULL
        drive(1, 16'h51, DW'(16'h5100), 1, 0);
        cyc();
        drive(1, 16'h52, DW'(16'h5200), 0, 0);
        cyc();
        drive(0, '0, '0, 0, 0);
        cyc();
        chk("arst_pre_full", 1, DW'(ir[1]), '0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_valid", k, DW'(ov[k]), '0);
            chk("arst_stall", k, got_sc(k), '0);
            chk("arst_ctrl", k, DW'(oc[k]), '0);
            chk("arst_data", k, od[k], '0);
            chk("arst_ready", k, DW'(ir[k]), '0);
        end
        cyc();
        rst_n = 1'b1;
        drive(0, '0, '0, 1, 0);
        cyc();
        // stall counter saturation
        drive(1, 16'h61, DW'(16'h6100), 0, 0);
        cyc();
        drive(0, '0, '0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 14) chk("sat_reach", 2, DW'(sc2), DW'(15));
        end
        chk("sat_hold", 2, DW'(sc2), DW'(15));
        chk("sat_wide", 0, DW'(sc0), DW'(20));
        chk("sat_wide", 1, DW'(sc1), DW'(20));
        drive(0, '0, '0, 1, 0);
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
